// File: rtl/traffic_display.sv
// traffic_display: converts A/B countdowns to BCD and scans them onto a 4-digit 7-segment display.
// Define TRAFFIC_DISPLAY_BLINK_EN to blink a direction's digits and LEDs while its lamp is yellow.
module traffic_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] acount,
   input  logic [7:0] bcount,
   input  logic [3:0] lampa,
   input  logic [3:0] lampb,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic [7:0] led,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, UPDATE} state_t;
   localparam int ScanW = $clog2(SCAN_DIV);

   state_t           state_q;
   logic [7:0]       capA_q, capB_q, shift_q;
   logic [2:0]       bitCnt_q;
   logic [11:0]      bcd_q, bcdA_q, bcdAdj, bcd_d;
   logic [3:0][7:0]  dig_q;
   logic             busy_q;
   logic [ScanW-1:0] scanCnt_q;
   logic [1:0]       idx_q;
   logic [3:0]       an_q;
   logic [7:0]       seg_q, led_q;
   logic             blankA, blankB, blankSel;
   logic [3:0]       ledA, ledB;

   function automatic logic [7:0] segCode(input logic [3:0] d);
      case (d)
         4'd0:    segCode = 8'hC0;
         4'd1:    segCode = 8'hF9;
         4'd2:    segCode = 8'hA4;
         4'd3:    segCode = 8'hB0;
         4'd4:    segCode = 8'h99;
         4'd5:    segCode = 8'h92;
         4'd6:    segCode = 8'h82;
         4'd7:    segCode = 8'hF8;
         4'd8:    segCode = 8'h80;
         4'd9:    segCode = 8'h90;
         default: segCode = 8'hFF;
      endcase
   endfunction

   // Returns {units, tens} so both directions pack straight into dig_q.
   function automatic logic [15:0] dirCodes(input logic [11:0] bcd);
      if (bcd[11:8] != 4'd0)
         dirCodes = {8'hBF, 8'hBF};
      else
         dirCodes = {segCode(bcd[3:0]), (bcd[7:4] == 4'd0) ? 8'hFF : segCode(bcd[7:4])};
   endfunction

   function automatic logic [3:0] safeLamp(input logic [3:0] l);
      safeLamp = (l != 4'd0 && (l & (l - 4'd1)) == 4'd0) ? l : 4'b0001;
   endfunction

   always_comb begin
      bcdAdj = bcd_q;
      for (int n = 0; n < 3; n++)
         if (bcd_q[4*n +: 4] >= 4'd5)
            bcdAdj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      bcd_d = {bcdAdj[10:0], shift_q[7]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         capA_q   <= 8'd0;
         capB_q   <= 8'd0;
         shift_q  <= 8'd0;
         bitCnt_q <= 3'd0;
         bcd_q    <= 12'd0;
         bcdA_q   <= 12'd0;
         dig_q    <= {8'hC0, 8'hFF, 8'hC0, 8'hFF};
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (acount != capA_q || bcount != capB_q) begin
                  capA_q   <= acount;
                  capB_q   <= bcount;
                  shift_q  <= acount;
                  bcd_q    <= 12'd0;
                  bitCnt_q <= 3'd0;
                  busy_q   <= 1'b1;
                  state_q  <= CONV_A;
               end
            end
            CONV_A: begin
               bcd_q    <= bcd_d;
               shift_q  <= {shift_q[6:0], 1'b0};
               bitCnt_q <= bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  bcdA_q  <= bcd_d;
                  bcd_q   <= 12'd0;
                  shift_q <= capB_q;
                  state_q <= CONV_B;
               end
            end
            CONV_B: begin
               bcd_q    <= bcd_d;
               shift_q  <= {shift_q[6:0], 1'b0};
               bitCnt_q <= bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7)
                  state_q <= UPDATE;
            end
            default: begin
               dig_q   <= {dirCodes(bcd_q), dirCodes(bcdA_q)};
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef TRAFFIC_DISPLAY_BLINK_EN
   localparam int BlinkW = $clog2(BLINK_DIV);
   logic [BlinkW-1:0] blinkCnt_q;
   logic              phase_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blinkCnt_q <= '0;
         phase_q    <= 1'b0;
      end else if (blinkCnt_q == BlinkW'(BLINK_DIV - 1)) begin
         blinkCnt_q <= '0;
         phase_q    <= ~phase_q;
      end else begin
         blinkCnt_q <= blinkCnt_q + BlinkW'(1);
      end
   end

   assign blankA = phase_q && (lampa == 4'b0010);
   assign blankB = phase_q && (lampb == 4'b0010);
`else
   // BLINK_DIV has no effect without blink support compiled in.
   if (BLINK_DIV < 1) begin : g_blinkDivUnused
   end
   assign blankA = 1'b0;
   assign blankB = 1'b0;
`endif

   assign blankSel = idx_q[1] ? blankB : blankA;
   assign ledA     = blankA ? 4'b0000 : safeLamp(lampa);
   assign ledB     = blankB ? 4'b0000 : safeLamp(lampb);

   // an and seg come from the same index in the same edge, so they never disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         scanCnt_q <= '0;
         idx_q     <= 2'd0;
         an_q      <= 4'b1111;
         seg_q     <= 8'hFF;
         led_q     <= 8'h00;
      end else begin
         an_q  <= ~(4'b0001 << idx_q);
         seg_q <= blankSel ? 8'hFF : dig_q[idx_q];
         led_q <= {ledB, ledA};
         if (scanCnt_q == ScanW'(SCAN_DIV - 1)) begin
            scanCnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
         end else begin
            scanCnt_q <= scanCnt_q + ScanW'(1);
         end
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign led  = led_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_traffic_display.sv
// tb_traffic_display: randomized self-checking bench for traffic_display against a decimal/timing model.
// Covers TRAFFIC_DISPLAY_BLINK_EN behaviour when that macro is defined.
module tb_traffic_display;
   localparam int SCAN  = 4;
   localparam int BLINK = 8;
`ifdef TRAFFIC_DISPLAY_BLINK_EN
   localparam bit BlinkBuilt = 1'b1;
`else
   localparam bit BlinkBuilt = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] acount = 8'd0, bcount = 8'd0;
   logic [3:0] lampa = 4'd0, lampb = 4'd0;
   logic [7:0] seg, led;
   logic [3:0] an;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] expDisp [4];
   logic [7:0] segTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   traffic_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
      .clk(clk), .rst(rst), .acount(acount), .bcount(bcount),
      .lampa(lampa), .lampb(lampb), .seg(seg), .an(an), .led(led), .busy(busy)
   );

   always #5 clk = ~clk;

   // cyc counts edges since reset release; the scanner and blink phase are derived from it.
   task automatic stepCycle();
      @(posedge clk);
      if (!rst) cyc++;
      #1;
   endtask

   task automatic refDigits(input int v, output logic [7:0] t, output logic [7:0] u);
      if (v >= 100) begin
         t = 8'hBF;
         u = 8'hBF;
      end else begin
         t = (v / 10 == 0) ? 8'hFF : segTab[v / 10];
         u = segTab[v % 10];
      end
   endtask

   task automatic setDisp(input int a, input int b);
      logic [7:0] t, u;
      refDigits(a, t, u);
      expDisp[0] = t;
      expDisp[1] = u;
      refDigits(b, t, u);
      expDisp[2] = t;
      expDisp[3] = u;
   endtask

   function automatic int scanIdx(input int k);
      return ((k - 1) / SCAN) % 4;
   endfunction

   function automatic bit blinkOn(input int k);
      return BlinkBuilt && (((k - 1) / BLINK) % 2 == 1);
   endfunction

   function automatic logic [3:0] refLamp(input logic [3:0] l);
      return ($countones(l) == 1) ? l : 4'b0001;
   endfunction

   function automatic logic [3:0] modelAn(input int k);
      return 4'b1111 ^ (4'b0001 << scanIdx(k));
   endfunction

   function automatic logic [7:0] modelSeg(input int k);
      int idx = scanIdx(k);
      logic [3:0] l = (idx < 2) ? lampa : lampb;
      if (blinkOn(k) && l == 4'b0010) return 8'hFF;
      return expDisp[idx];
   endfunction

   function automatic logic [7:0] modelLed(input int k);
      logic [3:0] a = (blinkOn(k) && lampa == 4'b0010) ? 4'b0000 : refLamp(lampa);
      logic [3:0] b = (blinkOn(k) && lampb == 4'b0010) ? 4'b0000 : refLamp(lampb);
      return {b, a};
   endfunction

   task automatic waitBusyHigh(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stepCycle();
         if (busy === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      acount = 8'd0; bcount = 8'd0; lampa = 4'd0; lampb = 4'd0;
      rst = 1'b1; cyc = 0;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checks++;
         if (an !== 4'b1111 || seg !== 8'hFF || led !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs actual an=%b seg=%h led=%h busy=%b required an=1111 seg=ff led=00 busy=0", an, seg, led, busy);
         end
      end
      rst = 1'b0;
      expDisp = '{8'hFF, 8'hC0, 8'hFF, 8'hC0};
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         checks++;
         if (an !== modelAn(cyc) || seg !== modelSeg(cyc) || led !== modelLed(cyc)) begin
            errors++;
            $display("[TB] FAIL reset_scan cyc=%0d actual an=%b seg=%h led=%h required an=%b seg=%h led=%h",
                     cyc, an, seg, led, modelAn(cyc), modelSeg(cyc), modelLed(cyc));
         end
      end
   endtask

   task automatic test_scan_order();
      bit ok;
      int n;
      acount = 8'd40; bcount = 8'd80; lampa = 4'b0001; lampb = 4'b0100;
      waitBusyHigh(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL busy_start actual busy=%b required 1 within 6 cycles", busy);
      end
      n = 1;
      for (int i = 0; i < 25; i++) begin
         stepCycle();
         if (busy !== 1'b1) break;
         n++;
      end
      checks++;
      if (n !== 17) begin
         errors++;
         $display("[TB] FAIL busy_length actual=%0d required=17", n);
      end
      setDisp(40, 80);
      stepCycle();
      for (int i = 0; i < 4 * SCAN; i++) begin
         stepCycle();
         checks++;
         if (an !== modelAn(cyc) || seg !== modelSeg(cyc)) begin
            errors++;
            $display("[TB] FAIL scan_order cyc=%0d actual an=%b seg=%h required an=%b seg=%h",
                     cyc, an, seg, modelAn(cyc), modelSeg(cyc));
         end
      end
   endtask

   task automatic test_dash();
      acount = 8'd5; bcount = 8'd150;
      setDisp(5, 150);
      repeat (25) stepCycle();
      for (int i = 0; i < 4 * SCAN; i++) begin
         stepCycle();
         checks++;
         if (an !== modelAn(cyc) || seg !== modelSeg(cyc)) begin
            errors++;
            $display("[TB] FAIL dash_blank cyc=%0d actual an=%b seg=%h required an=%b seg=%h",
                     cyc, an, seg, modelAn(cyc), modelSeg(cyc));
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      acount = 8'd55; bcount = 8'd12;
      waitBusyHigh(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL recapture_start actual busy=%b required 1 within 6 cycles", busy);
      end
      for (int k = 1; k <= 54; k++) begin
         stepCycle();
         if (k < 18)      setDisp(5, 150);
         else if (k < 36) setDisp(55, 12);
         else             setDisp(54, 12);
         checks++;
         if (an !== modelAn(cyc) || seg !== modelSeg(cyc)) begin
            errors++;
            $display("[TB] FAIL recapture_display k=%0d actual an=%b seg=%h required an=%b seg=%h",
                     k, an, seg, modelAn(cyc), modelSeg(cyc));
         end
         if (k == 17 || k == 18) begin
            checks++;
            if (busy !== (k == 18)) begin
               errors++;
               $display("[TB] FAIL recapture_busy k=%0d actual=%b required=%b", k, busy, (k == 18));
            end
         end
         if (k == 4) acount = 8'd54;
      end
   endtask

   task automatic test_led();
      lampa = 4'b0100; lampb = 4'b0110;
      stepCycle();
      checks++;
      if (led !== 8'h14) begin
         errors++;
         $display("[TB] FAIL led_failsafe actual=%h required=14", led);
      end
      lampa = 4'b1000; lampb = 4'b0000;
      stepCycle();
      checks++;
      if (led !== 8'h18) begin
         errors++;
         $display("[TB] FAIL led_zero_code actual=%h required=18", led);
      end
   endtask

   task automatic test_random();
      int a, b;
      for (int it = 0; it < 10; it++) begin
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         acount = 8'(a); bcount = 8'(b);
         lampa = 4'($urandom); lampb = 4'($urandom);
         stepCycle();
         checks++;
         if (led !== modelLed(cyc)) begin
            errors++;
            $display("[TB] FAIL rand_led it=%0d actual=%h required=%h", it, led, modelLed(cyc));
         end
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(2, 20)) stepCycle();
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            acount = 8'(a); bcount = 8'(b);
         end
         setDisp(a, b);
         repeat (45) stepCycle();
         for (int i = 0; i < 4 * SCAN; i++) begin
            stepCycle();
            checks++;
            if (an !== modelAn(cyc) || seg !== modelSeg(cyc) || led !== modelLed(cyc)) begin
               errors++;
               $display("[TB] FAIL rand_display it=%0d a=%0d b=%0d actual an=%b seg=%h led=%h required an=%b seg=%h led=%h",
                        it, a, b, an, seg, led, modelAn(cyc), modelSeg(cyc), modelLed(cyc));
            end
         end
      end
   endtask

`ifdef TRAFFIC_DISPLAY_BLINK_EN
   task automatic test_blink();
      acount = 8'd0; bcount = 8'd0; lampa = 4'b0010; lampb = 4'b0100;
      rst = 1'b1; cyc = 0;
      stepCycle();
      stepCycle();
      rst = 1'b0;
      expDisp = '{8'hFF, 8'hC0, 8'hFF, 8'hC0};
      for (int i = 0; i < 5 * BLINK; i++) begin
         stepCycle();
         checks++;
         if (seg !== modelSeg(cyc) || led !== modelLed(cyc)) begin
            errors++;
            $display("[TB] FAIL blink cyc=%0d actual seg=%h led=%h required seg=%h led=%h",
                     cyc, seg, led, modelSeg(cyc), modelLed(cyc));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan_order();
      test_dash();
      test_back_to_back();
      test_led();
      test_random();
`ifdef TRAFFIC_DISPLAY_BLINK_EN
      test_blink();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
